// File: rtl/seq_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_pkg
// Description : Shared defaults and helpers for the programmable serial
//               sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detector_pkg;

    localparam int          DEF_PAT_LEN = 8;
    localparam int          DEF_CNT_W   = 8;
    localparam logic [7:0]  DEF_PATTERN = 8'b0110_1101;

    // Width needed to hold a bit count in the range 0..pat_len inclusive.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_match_counter
// Description : Saturating match counter with sticky saturation flag.
//               A clear in the same cycle as an increment yields a count of 1.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_match_counter
    import seq_detector_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over hold; a coincident increment is applied after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (count == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_prog
// Description : Run-time programmable serial sequence detector with per-bit
//               don't-care mask, overlapping / non-overlapping detection and
//               a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_prog #(
    parameter int                  PAT_LEN     = seq_detector_pkg::DEF_PAT_LEN,
    parameter int                  CNT_W       = seq_detector_pkg::DEF_CNT_W,
    parameter logic [PAT_LEN-1:0]  DEF_PATTERN = seq_detector_pkg::DEF_PATTERN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [PAT_LEN-1:0] cfg_mask,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat
);

    import seq_detector_pkg::*;

    localparam int             FILL_W    = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] mask;
    logic               ovl;
    logic [FILL_W-1:0]  fill;

    logic               accept;
    logic [PAT_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_next;
    logic               match;

    // A bit offered alongside a configuration load is discarded.
    assign accept    = in_valid & ~cfg_load;
    assign hist_next = {hist[PAT_LEN-2:0], in_bit};
    assign fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);

    // Masked compare on the post-shift window; masked-off bits always agree.
    assign match = accept
                 && (fill_next == FILL_FULL)
                 && (&((hist_next ~^ pat) | ~mask));

    // History, fill, active configuration and the registered match pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist         <= '0;
            fill         <= '0;
            pat          <= DEF_PATTERN;
            mask         <= '1;
            ovl          <= 1'b1;
            seq_detected <= 1'b0;
        end else if (cfg_load) begin
            pat          <= cfg_pattern;
            mask         <= cfg_mask;
            ovl          <= cfg_overlap;
            hist         <= '0;
            fill         <= '0;
            seq_detected <= 1'b0;
        end else begin
            seq_detected <= match;
            if (accept) begin
                hist <= hist_next;
                // Non-overlapping mode demands a full window of fresh bits.
                fill <= (match && !ovl) ? '0 : fill_next;
            end
        end
    end

    sat_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clear),
        .count (match_count),
        .sat   (cnt_sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_prog
// Description : Self-checking bench for seq_detector_prog. Two instances
//               (CNT_W=8 and CNT_W=2) share one stimulus stream and are
//               compared every cycle against a window-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_prog;

    localparam int         PL   = 8;
    localparam logic [7:0] DEFP = 8'b0110_1101;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_bit, cfg_load, cfg_overlap, cnt_clear;
    logic [7:0] cfg_pattern, cfg_mask;
    logic       det8, sat8, det2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_detector_prog #(.PAT_LEN(8), .CNT_W(8), .DEF_PATTERN(DEFP)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .seq_detected(det8), .match_count(cnt8), .cnt_sat(sat8)
    );

    seq_detector_prog #(.PAT_LEN(8), .CNT_W(2), .DEF_PATTERN(DEFP)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .seq_detected(det2), .match_count(cnt2), .cnt_sat(sat2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the list of bits that may still take part in a match.
    bit         win[$];
    logic [7:0] m_pat, m_mask;
    bit         m_ovl, m_det, m_hit;
    int         m_matches;
    bit         compare_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit window_matches();
        if (win.size() != PL) return 1'b0;
        for (int i = 0; i < PL; i++) begin
            if (m_mask[PL-1-i] && (win[i] != m_pat[PL-1-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            win.delete();
            m_pat     = DEFP;
            m_mask    = 8'hFF;
            m_ovl     = 1'b1;
            m_det     = 1'b0;
            m_matches = 0;
        end else begin
            m_hit = 1'b0;
            if (cfg_load) begin
                m_pat  = cfg_pattern;
                m_mask = cfg_mask;
                m_ovl  = cfg_overlap;
                win.delete();
            end else if (in_valid) begin
                win.push_back(in_bit);
                if (win.size() > PL) void'(win.pop_front());
                m_hit = window_matches();
                if (m_hit && !m_ovl) win.delete();
            end
            if (cnt_clear) m_matches = m_hit ? 1 : 0;
            else if (m_hit) m_matches++;
            m_det = m_hit;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (compare_en) begin
            if (!reset) begin
                check("rst_det8", det8, 0);  check("rst_cnt8", cnt8, 0);  check("rst_sat8", sat8, 0);
                check("rst_det2", det2, 0);  check("rst_cnt2", cnt2, 0);  check("rst_sat2", sat2, 0);
            end else begin
                check("det8", det8, m_det);
                check("cnt8", cnt8, (m_matches > 255) ? 255 : m_matches);
                check("sat8", sat8, m_matches > 255);
                check("det2", det2, m_det);
                check("cnt2", cnt2, (m_matches > 3) ? 3 : m_matches);
                check("sat2", sat2, m_matches > 3);
            end
        end
    end

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic cyc(input logic v, input logic b, input logic ld = 1'b0, input logic clr = 1'b0);
        in_valid  = v;
        in_bit    = b;
        cfg_load  = ld;
        cnt_clear = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            logic [31:0] tmp;
            tmp = bits;
            cyc(1'b1, tmp[i]);
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [7:0] m, input logic o, input logic clr);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = o;
        cyc(1'b0, 1'b0, 1'b1, clr);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cnt_clear = 1'b0; cfg_pattern = 8'h00; cfg_mask = 8'hFF; cfg_overlap = 1'b1;
        @(posedge clk);
        #1;
        compare_en = 1'b1;
        cyc(0, 0); cyc(0, 0);
        check("lit_reset_det", det8, 0);
        check("lit_reset_cnt", cnt8, 0);
        reset = 1'b1;
        cyc(0, 0);

        // Default pattern, single pulse on the 8th bit.
        send_bits(32'b0110_1101, 8);
        check("lit_default_det", det8, 1);
        check("lit_default_cnt", cnt8, 1);
        check("lit_model_cnt", m_matches, 1);
        cyc(0, 0);
        check("lit_pulse_one_cycle", det8, 0);

        // Overlapping: pulses after bits 8 and 11.
        load(DEFP, 8'hFF, 1'b1, 1'b1);
        send_bits(32'b0110_1101, 8);
        check("lit_ovl_det8", det8, 1);
        send_bits(32'b101, 3);
        check("lit_ovl_det11", det8, 1);
        check("lit_ovl_cnt", cnt8, 2);
        // Non-overlapping: only the bit-8 pulse.
        load(DEFP, 8'hFF, 1'b0, 1'b0);
        send_bits(32'b0110_1101, 8);
        check("lit_novl_det8", det8, 1);
        send_bits(32'b101, 3);
        check("lit_novl_det11", det8, 0);
        check("lit_novl_cnt", cnt8, 3);

        // Masked compare: only the upper nibble 0110 matters.
        load(8'h60, 8'hF0, 1'b0, 1'b0);
        send_bits(32'b0110_1010, 8);
        check("lit_mask_det8", det8, 1);
        send_bits(32'b0110_0001, 8);
        check("lit_mask_det16", det8, 1);
        check("lit_mask_cnt8", cnt8, 5);
        check("lit_sat_cnt2", cnt2, 3);
        check("lit_sat_flag2", sat2, 1);
        check("lit_nosat_flag8", sat8, 0);

        // Clear coincident with a match counts that match.
        send_bits(32'b011_0000, 7);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("lit_clr_det", det8, 1);
        check("lit_clr_cnt8", cnt8, 1);
        check("lit_clr_cnt2", cnt2, 1);
        check("lit_clr_sat2", sat2, 0);

        // Idle gap is transparent; a bit offered with cfg_load is dropped.
        load(DEFP, 8'hFF, 1'b1, 1'b0);
        send_bits(32'b0110, 4);
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        send_bits(32'b1101, 4);
        check("lit_gap_det", det8, 1);
        check("lit_gap_cnt", cnt8, 2);
        cfg_pattern = DEFP; cfg_mask = 8'hFF; cfg_overlap = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("lit_load_drop_det", det8, 0);
        send_bits(32'b011_0110, 7);
        check("lit_refill_det7", det8, 0);
        send_bits(32'b1, 1);
        check("lit_refill_det8", det8, 1);
        check("lit_refill_cnt", cnt8, 3);

        // Mid-stream reset.
        send_bits(32'b01101, 5);
        reset = 1'b0;
        #1;
        check("lit_async_det", det8, 0);
        check("lit_async_cnt", cnt8, 0);
        cyc(0, 0); cyc(0, 0);
        reset = 1'b1;
        send_bits(32'b011_0110, 7);
        check("lit_after_rst_det7", det8, 0);
        send_bits(32'b1, 1);
        check("lit_after_rst_det8", det8, 1);
        check("lit_after_rst_cnt", cnt8, 1);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                reset = 1'b0;
                cyc(0, 0); cyc(0, 0);
                reset = 1'b1;
            end else if (r < 6) begin
                load(8'($urandom), 8'($urandom & $urandom & $urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            end else begin
                cyc(1'($urandom_range(0, 9) < 8), 1'($urandom), 1'b0, 1'($urandom_range(0, 99) < 2));
            end
        end

        cyc(0, 0);
        compare_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
